frfb_mem_arb: RTL and testbench



---
 rtl/frfb_mem_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_frfb_mem_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frfb_mem_arb.sv
// ---------------------------------------------------------------------------
// frfb_mem_arb
// Round-robin arbiter that time-shares one external memory address/strobe
// port among NUM_CH streaming framebuffer channels (capture and scan-out
// FIFOs). Each channel keeps its own frame-word counter, base address and
// transfer direction. A frame sync clears that channel's counter.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   sys_init_done  memory ready; new accesses start only while high
//   ch_req         per-channel level request
//   ch_vsync_n     per-channel active-low frame sync (clears counter)
//   ch_grant       one-hot owner of the access in flight, zero when idle
//   ch_done        one-cycle completion pulse for the owning channel
//   sys_addr       memory address (holds its last value while idle)
//   sys_adsn       active-low address strobe, one cycle per access
//   sys_r_wn       1 = read, 0 = write
//   sys_ack        memory handshake: high while busy, low when finished
//   arb_err        sticky ack-timeout flag
//
// Optional build macro FRFB_ARB_TIMEOUT_EN adds an ack watchdog of TMO_CYC
// cycles. When the watchdog expires, the access is aborted and arb_err is set.
// If the macro is not defined, arb_err is tied low and the FSM waits for
// sys_ack indefinitely.
// ---------------------------------------------------------------------------
module frfb_mem_arb #(
  parameter int                         NUM_CH      = 4,
  parameter int                         ADDR_W      = 15,
  parameter int                         FRAME_WORDS = 32768,
  parameter logic [NUM_CH-1:0]          CH_WR_MASK  = 4'b0101,
  parameter logic [NUM_CH*ADDR_W-1:0]   CH_BASE     = '0,
  parameter int                         TMO_CYC     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sys_init_done,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_vsync_n,
  output logic [NUM_CH-1:0] ch_grant,
  output logic [NUM_CH-1:0] ch_done,
  output logic [ADDR_W-1:0] sys_addr,
  output logic              sys_adsn,
  output logic              sys_r_wn,
  input  logic              sys_ack,
  output logic              arb_err
);

  localparam int                PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t              state_reg, state_next;
  logic [PW-1:0]       cur_reg, cur_next;
  logic [PW-1:0]       rr_reg, rr_next;
  logic [NUM_CH-1:0]   grant_reg, grant_next;
  logic [NUM_CH-1:0]   done_reg, done_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                adsn_reg, adsn_next;
  logic                rwn_reg, rwn_next;

  logic [NUM_CH*ADDR_W-1:0] cnt_flat;
  logic                sel_found;
  logic [PW-1:0]       sel_idx;
  logic [ADDR_W-1:0]   addr_sel;
  logic                wr_sel;
  logic                fin_ok;     // access completed normally this cycle
  logic                fin_abort;  // access abandoned by the watchdog
  logic                tmo_hit;
  logic [PW-1:0]       cur_inc;

  // First requester at or above the round-robin pointer, with wrap.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!sel_found && ch_req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    wr_sel   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_idx == PW'(k)) begin
        addr_sel = CH_BASE[k*ADDR_W +: ADDR_W] + cnt_flat[k*ADDR_W +: ADDR_W];
        wr_sel   = CH_WR_MASK[k];
      end
    end
  end

  assign cur_inc = (cur_reg == PW'(NUM_CH - 1)) ? '0 : cur_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    rr_next    = rr_reg;
    grant_next = grant_reg;
    done_next  = '0;
    addr_next  = addr_reg;
    adsn_next  = 1'b1;
    rwn_next   = rwn_reg;
    fin_ok     = 1'b0;
    fin_abort  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sys_init_done && sel_found) begin
          state_next = ISSUE;
          cur_next   = sel_idx;
          grant_next = NUM_CH'(1) << sel_idx;
          addr_next  = addr_sel;
          rwn_next   = ~wr_sel;
          adsn_next  = 1'b0;
        end
      end
      ISSUE: state_next = WAIT_HI;
      WAIT_HI, WAIT_LO: begin
        if (tmo_hit) begin
          fin_abort = 1'b1;
        end else if (state_reg == WAIT_HI) begin
          if (sys_ack) state_next = WAIT_LO;
        end else if (!sys_ack) begin
          fin_ok    = 1'b1;
          done_next = grant_reg;
        end
        if (fin_ok || fin_abort) begin
          state_next = IDLE;
          grant_next = '0;
          rwn_next   = 1'b1;
          rr_next    = cur_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cur_reg   <= '0;
      rr_reg    <= '0;
      grant_reg <= '0;
      done_reg  <= '0;
      addr_reg  <= '0;
      adsn_reg  <= 1'b1;
      rwn_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      rr_reg    <= rr_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      addr_reg  <= addr_next;
      adsn_reg  <= adsn_next;
      rwn_reg   <= rwn_next;
    end
  end

  // Per-channel frame counters. A frame sync seen while the channel owns the
  // bus is remembered in pend_reg so that it still wins over the increment at
  // completion, even if the sync pulse has ended by then.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ADDR_W-1:0] cnt_reg;
    logic              pend_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg  <= '0;
        pend_reg <= 1'b0;
      end else if (grant_reg[gi]) begin
        if (fin_ok || fin_abort) begin
          pend_reg <= 1'b0;
          if (pend_reg || !ch_vsync_n[gi]) cnt_reg <= '0;
          else if (fin_ok)                 cnt_reg <= (cnt_reg == LAST_WORD) ? '0 : cnt_reg + 1'b1;
        end else if (!ch_vsync_n[gi]) begin
          pend_reg <= 1'b1;
        end
      end else begin
        pend_reg <= 1'b0;
        if (!ch_vsync_n[gi]) cnt_reg <= '0;
      end
    end

    assign cnt_flat[gi*ADDR_W +: ADDR_W] = cnt_reg;
  end

`ifdef FRFB_ARB_TIMEOUT_EN
  // Counts cycles spent waiting on sys_ack. It restarts for every access.
  logic [15:0] wdog_reg;
  logic        err_reg;

  assign tmo_hit = (state_reg == WAIT_HI || state_reg == WAIT_LO) &&
                   (wdog_reg == 16'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (state_reg == WAIT_HI || state_reg == WAIT_LO) wdog_reg <= wdog_reg + 1'b1;
      else                                             wdog_reg <= '0;
      if (fin_abort) err_reg <= 1'b1;
    end
  end

  assign arb_err = err_reg;
`else
  assign tmo_hit = 1'b0;
  assign arb_err = 1'b0;
`endif

  assign ch_grant = grant_reg;
  assign ch_done  = done_reg;
  assign sys_addr = addr_reg;
  assign sys_adsn = adsn_reg;
  assign sys_r_wn = rwn_reg;

endmodule

// File: tb/tb_frfb_mem_arb.sv
// Testbench for frfb_mem_arb: 4 channels, FRAME_WORDS=4, mixed bases, TMO_CYC=8.
module tb_frfb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_init_done;
  logic [3:0]  ch_req;
  logic [3:0]  ch_vsync_n;
  logic [3:0]  ch_grant;
  logic [3:0]  ch_done;
  logic [14:0] sys_addr;
  logic        sys_adsn;
  logic        sys_r_wn;
  logic        sys_ack;
  logic        arb_err;

  frfb_mem_arb #(
    .NUM_CH(4), .ADDR_W(15), .FRAME_WORDS(4), .CH_WR_MASK(4'b0101),
    .CH_BASE({15'h7FFE, 15'h0200, 15'h0100, 15'h0000}), .TMO_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .sys_init_done(sys_init_done), .ch_req(ch_req),
    .ch_vsync_n(ch_vsync_n), .ch_grant(ch_grant), .ch_done(ch_done),
    .sys_addr(sys_addr), .sys_adsn(sys_adsn), .sys_r_wn(sys_r_wn),
    .sys_ack(sys_ack), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [14:0] a;
    logic        rwn;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    int          r;
    int          h;
    logic [3:0]  exp_g;
    logic [14:0] exp_addr;
    logic        exp_rwn;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[15];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  logic prev_adsn = 1'b1;
  logic [3:0] prev_done = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (!sys_adsn) begin
        check("strobe_width", prev_adsn, 1);
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_strobe: grant 0x%0h addr 0x%0h, no access expected", ch_grant, sys_addr);
        end else begin
          mon_e = sb.pop_front();
          check("grant", ch_grant, mon_e.g);
          check("addr", sys_addr, mon_e.a);
          check("r_wn", sys_r_wn, mon_e.rwn);
          $display("[TB] access grant=%b addr=0x%04h r_wn=%0d", ch_grant, sys_addr, sys_r_wn);
        end
      end
      if (ch_done != 0) begin
        done_seen++;
        check("done_width", prev_done, 0);
      end
      prev_adsn <= sys_adsn;
      prev_done <= ch_done;
    end
  end

  task automatic start_access(input logic [3:0] req, input logic [3:0] eg,
                              input logic [14:0] ea, input logic er);
    exp_t e;
    int   k;
    e.g = eg; e.a = ea; e.rwn = er;
    sb.push_back(e);
    ch_req = req;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!sys_adsn) break;
    end
    ch_req = 4'h0;
    check("issue_lat", k, 1);
  endtask

  task automatic finish_access(input int r, input int h, input logic [3:0] eg);
    int k;
    if (r > 0) repeat (r) @(negedge clk);
    sys_ack = 1'b1;
    repeat (h) @(negedge clk);
    sys_ack = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ch_done != 0) break;
    end
    done_exp++;
    check("done_lat", k, 1);
    check("done_ch", ch_done, eg);
    check("idle_grant", ch_grant, 0);
    check("idle_r_wn", sys_r_wn, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    //          req      r  h  grant    addr      r_wn
    tbl[0]  = '{4'b0001, 2, 2, 4'b0001, 15'h0000, 1'b0};
    tbl[1]  = '{4'b0001, 1, 3, 4'b0001, 15'h0001, 1'b0};
    tbl[2]  = '{4'b1000, 0, 2, 4'b1000, 15'h7FFE, 1'b1};
    tbl[3]  = '{4'b1111, 0, 2, 4'b0001, 15'h0002, 1'b0};
    tbl[4]  = '{4'b1111, 0, 2, 4'b0010, 15'h0100, 1'b1};
    tbl[5]  = '{4'b1111, 0, 2, 4'b0100, 15'h0200, 1'b0};
    tbl[6]  = '{4'b1111, 0, 2, 4'b1000, 15'h7FFF, 1'b1};
    tbl[7]  = '{4'b1111, 0, 2, 4'b0001, 15'h0003, 1'b0};
    tbl[8]  = '{4'b0001, 3, 4, 4'b0001, 15'h0000, 1'b0};
    tbl[9]  = '{4'b1000, 0, 2, 4'b1000, 15'h0000, 1'b1};
    tbl[10] = '{4'b0110, 0, 2, 4'b0010, 15'h0101, 1'b1};
    tbl[11] = '{4'b0110, 0, 2, 4'b0100, 15'h0201, 1'b0};
    tbl[12] = '{4'b0010, 0, 2, 4'b0010, 15'h0102, 1'b1};
    tbl[13] = '{4'b0010, 0, 2, 4'b0010, 15'h0103, 1'b1};
    tbl[14] = '{4'b0010, 0, 2, 4'b0010, 15'h0100, 1'b1};

    rst = 1'b1; sys_init_done = 1'b0; ch_req = 4'hF; ch_vsync_n = 4'hF; sys_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adsn", sys_adsn, 1);
    check("rst_grant", ch_grant, 0);
    check("rst_addr", sys_addr, 0);
    check("rst_r_wn", sys_r_wn, 1);
    check("rst_done", ch_done, 0);
    check("rst_err", arb_err, 0);
    rst = 1'b0;
    // Memory not ready: requests must be ignored.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("noinit_adsn", sys_adsn, 1);
      check("noinit_grant", ch_grant, 0);
    end
    ch_req = 4'h0;
    sys_init_done = 1'b1;

    for (int i = 0; i < 15; i++) begin
      start_access(tbl[i].req, tbl[i].exp_g, tbl[i].exp_addr, tbl[i].exp_rwn);
      finish_access(tbl[i].r, tbl[i].h, tbl[i].exp_g);
    end

    // Frame sync during an owned access: the next access restarts at the base.
    start_access(4'b0010, 4'b0010, 15'h0101, 1'b1);
    ch_vsync_n[1] = 1'b0;
    @(negedge clk);
    ch_vsync_n[1] = 1'b1;
    finish_access(0, 2, 4'b0010);
    start_access(4'b0010, 4'b0010, 15'h0100, 1'b1);
    finish_access(0, 2, 4'b0010);

    // Frame sync on an idle channel clears its counter immediately.
    ch_vsync_n[2] = 1'b0;
    @(negedge clk);
    ch_vsync_n[2] = 1'b1;
    start_access(4'b0100, 4'b0100, 15'h0200, 1'b0);
    finish_access(0, 2, 4'b0100);

    // Reset while waiting for ack.
    start_access(4'b0001, 4'b0001, 15'h0001, 1'b0);
    @(negedge clk);
    check("waithi_grant", ch_grant, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_adsn", sys_adsn, 1);
    check("midrst_grant", ch_grant, 0);
    check("midrst_addr", sys_addr, 0);
    check("midrst_r_wn", sys_r_wn, 1);
    check("midrst_done", ch_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_done", ch_done, 0);
    start_access(4'b0001, 4'b0001, 15'h0000, 1'b0);
    finish_access(1, 2, 4'b0001);

    // Ack never arrives.
    start_access(4'b0100, 4'b0100, 15'h0200, 1'b0);
`ifdef FRFB_ARB_TIMEOUT_EN
    repeat (8) @(negedge clk);
    check("tmo_hold_grant", ch_grant, 4'b0100);
    check("tmo_hold_err", arb_err, 0);
    @(negedge clk);
    check("tmo_abort_grant", ch_grant, 0);
    check("tmo_abort_err", arb_err, 1);
    check("tmo_abort_done", ch_done, 0);
    check("tmo_abort_r_wn", sys_r_wn, 1);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", arb_err, 1);
    start_access(4'b0101, 4'b0001, 15'h0001, 1'b0);
    finish_access(0, 2, 4'b0001);
    start_access(4'b0100, 4'b0100, 15'h0200, 1'b0);
    finish_access(0, 2, 4'b0100);
`else
    repeat (20) @(negedge clk);
    check("noack_grant", ch_grant, 4'b0100);
    check("noack_err", arb_err, 0);
    finish_access(0, 2, 4'b0100);
    start_access(4'b0101, 4'b0001, 15'h0001, 1'b0);
    finish_access(0, 2, 4'b0001);
    start_access(4'b0100, 4'b0100, 15'h0201, 1'b0);
    finish_access(0, 2, 4'b0100);
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", done_seen, done_exp);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
